// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command decoder (SYNC/CMD/ADDR/LEN/DATA[/CSUM] framing).
package spi_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_CSUM
  } state_t;

  localparam logic [7:0] CMD_WRITE     = 8'h01;
  localparam logic [7:0] CMD_CLEAR     = 8'h02;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'h77;

endpackage

// File: rtl/spi_edge_detect.sv
// One-cycle pulse on the rising edge of a level input; combinational from the current level, so
// the pulse lines up with the cycle the level first rises. Zero latency, no backpressure.
module spi_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_pulse
);

  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= i_level;
  end

  assign o_pulse = i_level & ~r_prev;

endmodule

// File: rtl/spi_cmd_decoder.sv
// Decodes SYNC/CMD/ADDR/LEN/payload byte packets into a register file; write strobes one cycle after each byte.
// Optional trailing XOR checksum byte enabled by macro SPI_CMD_CHECKSUM_EN.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                NUM_REGS    = 16,
  parameter logic [DATA_W-1:0] SYNC_BYTE   = DATA_W'(SYNC_BYTE_DEF),
  parameter int                TIMEOUT_CYC = 1000,
  localparam int               ADDR_W      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_ready_in,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] data_out,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              pkt_done,
  output logic              pkt_err
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic w_accept;

  state_t            r_state;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [ADDR_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_remain;
  logic [TO_W-1:0]   r_to_cnt;
  logic [DATA_W-1:0] r_data_out;
  logic              r_wr_strobe;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_pkt_done;
  logic              r_pkt_err;
`ifdef SPI_CMD_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
`endif

  spi_edge_detect u_edge (
    .clk     (clk),
    .rst     (rst),
    .i_level (data_ready_in),
    .o_pulse (w_accept)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_remain    <= '0;
      r_to_cnt    <= '0;
      r_data_out  <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_pkt_done  <= 1'b0;
      r_pkt_err   <= 1'b0;
`ifdef SPI_CMD_CHECKSUM_EN
      r_csum      <= '0;
`endif
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_wr_strobe <= 1'b0;
      r_pkt_done  <= 1'b0;
      r_pkt_err   <= 1'b0;
      r_data_out  <= r_regs[rd_addr];

      if (r_state == ST_IDLE || w_accept) r_to_cnt <= '0;
      else                                r_to_cnt <= r_to_cnt + 1'b1;

      // Timeout only fires on a cycle with no accepted byte, so it never collides with pkt_done.
      if (r_state != ST_IDLE && !w_accept && r_to_cnt == TO_LAST) begin
        r_pkt_err <= 1'b1;
        r_state   <= ST_IDLE;
      end else if (w_accept) begin
        case (r_state)
          ST_IDLE: begin
            if (data_in == SYNC_BYTE) r_state <= ST_CMD;
          end
          ST_CMD: begin
            if (data_in == DATA_W'(CMD_WRITE)) begin
              r_state <= ST_ADDR;
`ifdef SPI_CMD_CHECKSUM_EN
              r_csum  <= data_in;
`endif
            end else if (data_in == DATA_W'(CMD_CLEAR)) begin
              for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
              r_pkt_done <= 1'b1;
              r_state    <= ST_IDLE;
            end else begin
              r_pkt_err <= 1'b1;
              r_state   <= ST_IDLE;
            end
          end
          ST_ADDR: begin
            r_ptr   <= data_in[ADDR_W-1:0];
            r_state <= ST_LEN;
`ifdef SPI_CMD_CHECKSUM_EN
            r_csum  <= r_csum ^ data_in;
`endif
          end
          ST_LEN: begin
            r_remain <= data_in;
`ifdef SPI_CMD_CHECKSUM_EN
            r_csum   <= r_csum ^ data_in;
            r_state  <= (data_in == '0) ? ST_CSUM : ST_DATA;
`else
            if (data_in == '0) begin
              r_pkt_done <= 1'b1;
              r_state    <= ST_IDLE;
            end else begin
              r_state <= ST_DATA;
            end
`endif
          end
          ST_DATA: begin
            r_regs[r_ptr] <= data_in;
            r_wr_strobe   <= 1'b1;
            r_wr_addr     <= r_ptr;
            r_wr_data     <= data_in;
            r_ptr         <= r_ptr + 1'b1;
            r_remain      <= r_remain - 1'b1;
`ifdef SPI_CMD_CHECKSUM_EN
            r_csum        <= r_csum ^ data_in;
            if (r_remain == DATA_W'(1)) r_state <= ST_CSUM;
`else
            if (r_remain == DATA_W'(1)) begin
              r_pkt_done <= 1'b1;
              r_state    <= ST_IDLE;
            end
`endif
          end
`ifdef SPI_CMD_CHECKSUM_EN
          ST_CSUM: begin
            if (data_in == r_csum) r_pkt_done <= 1'b1;
            else                   r_pkt_err  <= 1'b1;
            r_state <= ST_IDLE;
          end
`endif
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign data_out  = r_data_out;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign pkt_done  = r_pkt_done;
  assign pkt_err   = r_pkt_err;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: expected writes and packet events are queued as bytes are
// driven and popped as the DUT pulses; register contents are compared against a reference array.
module tb_spi_cmd_decoder;

  localparam int NR = 16;
  localparam int TO = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_ready_in;
  logic [3:0] rd_addr;
  logic [7:0] data_out;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       pkt_done;
  logic       pkt_err;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  model [NR];
  logic [11:0] exp_wr[$];
  logic [1:0]  exp_evt[$];

  localparam logic [1:0] EV_DONE = 2'b01;
  localparam logic [1:0] EV_ERR  = 2'b10;

  always #5 clk = ~clk;

  spi_cmd_decoder #(
    .DATA_W      (8),
    .NUM_REGS    (NR),
    .SYNC_BYTE   (8'h77),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_ready_in (data_ready_in),
    .rd_addr       (rd_addr),
    .data_out      (data_out),
    .wr_strobe     (wr_strobe),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .pkt_done      (pkt_done),
    .pkt_err       (pkt_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Pop-and-compare on every DUT pulse; an empty queue yields an expected value the DUT cannot match.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_strobe) begin
        logic [12:0] e;
        e = (exp_wr.size() != 0) ? {1'b1, exp_wr.pop_front()} : 13'h0;
        check_eq("wr_strobe", {1'b1, wr_addr, wr_data}, e);
      end
      if (pkt_done || pkt_err) begin
        logic [1:0] ev;
        ev = (exp_evt.size() != 0) ? exp_evt.pop_front() : 2'b00;
        check_eq("pkt_event", {pkt_err, pkt_done}, ev);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    data_in       = b;
    data_ready_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 data_ready_in = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic wr_pkt(input logic [7:0] addr, input int n, input logic [7:0] d0,
                        input logic [7:0] d1, input bit skip_sync);
    logic [7:0] d [2];
    logic [3:0] a;
    logic [7:0] cs;
    d[0] = d0;
    d[1] = d1;
    a    = addr[3:0];
    cs   = 8'h01 ^ addr ^ 8'(n);
    if (!skip_sync) send_byte(8'h77);
    send_byte(8'h01);
    send_byte(addr);
`ifndef SPI_CMD_CHECKSUM_EN
    if (n == 0) exp_evt.push_back(EV_DONE);
`endif
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      exp_wr.push_back({a, d[i]});
      model[a] = d[i];
      a        = a + 4'd1;
      cs       = cs ^ d[i];
`ifndef SPI_CMD_CHECKSUM_EN
      if (i == n - 1) exp_evt.push_back(EV_DONE);
`endif
      send_byte(d[i]);
    end
`ifdef SPI_CMD_CHECKSUM_EN
    exp_evt.push_back(EV_DONE);
    send_byte(cs);
`endif
  endtask

  task automatic readback(input int a);
    @(posedge clk); #1 rd_addr = 4'(a);
    @(posedge clk); #1;
    check_eq($sformatf("reg%0d", a), data_out, model[a]);
  endtask

  initial begin
    rst           = 1'b1;
    data_in       = 8'h00;
    data_ready_in = 1'b0;
    rd_addr       = 4'd0;
    for (int i = 0; i < NR; i++) model[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data_out", data_out, 0);
    check_eq("rst_wr_strobe", wr_strobe, 0);
    check_eq("rst_pkt_done", pkt_done, 0);
    check_eq("rst_pkt_err", pkt_err, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    wr_pkt(8'h03, 2, 8'hAA, 8'h55, 1'b0);
    readback(3);
    readback(4);

    wr_pkt(8'h0F, 2, 8'h11, 8'h22, 1'b0);
    readback(15);
    readback(0);

    wr_pkt(8'h23, 1, 8'h9D, 8'h00, 1'b0);
    readback(3);

    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h77);
    exp_evt.push_back(EV_ERR);
    send_byte(8'h05);
    wr_pkt(8'h00, 1, 8'h5A, 8'h00, 1'b0);
    readback(0);

    // SYNC held as a long level must count once; a repeat would be rejected as a bad CMD.
    @(posedge clk); #1;
    data_in       = 8'h77;
    data_ready_in = 1'b1;
    repeat (25) @(posedge clk);
    #1 data_ready_in = 1'b0;
    repeat (2) @(posedge clk);
    wr_pkt(8'h05, 1, 8'hC3, 8'h00, 1'b1);
    readback(5);

    wr_pkt(8'h07, 0, 8'h00, 8'h00, 1'b0);

    exp_evt.push_back(EV_DONE);
    send_byte(8'h77);
    send_byte(8'h02);
    for (int i = 0; i < NR; i++) model[i] = 8'h00;
    readback(3);
    readback(15);

    send_byte(8'h77);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    exp_wr.push_back({4'd2, 8'hAA});
    model[2] = 8'hAA;
    send_byte(8'hAA);
    exp_evt.push_back(EV_ERR);
    repeat (TO - 20) @(posedge clk);
    #1 check_eq("timeout_not_early", exp_evt.size(), 1);
    repeat (40) @(posedge clk);
    #1 check_eq("timeout_fired", exp_evt.size(), 0);
    readback(2);
    wr_pkt(8'h08, 1, 8'h81, 8'h00, 1'b0);
    readback(8);

`ifdef SPI_CMD_CHECKSUM_EN
    send_byte(8'h77);
    send_byte(8'h01);
    send_byte(8'h09);
    send_byte(8'h01);
    exp_wr.push_back({4'd9, 8'h44});
    model[9] = 8'h44;
    send_byte(8'h44);
    exp_evt.push_back(EV_ERR);
    send_byte(8'h00);
    readback(9);
`endif

    send_byte(8'h77);
    send_byte(8'h01);
    send_byte(8'h06);
    send_byte(8'h02);
    exp_wr.push_back({4'd6, 8'hEE});
    model[6] = 8'hEE;
    send_byte(8'hEE);
    readback(6);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_eq("midpkt_rst_data_out", data_out, 0);
    for (int i = 0; i < NR; i++) model[i] = 8'h00;
    rst = 1'b0;
    for (int i = 0; i < NR; i++) readback(i);
    wr_pkt(8'h01, 1, 8'h3C, 8'h00, 1'b0);
    readback(1);

    repeat (5) @(posedge clk);
    #1;
    check_eq("wr_queue_drained", exp_wr.size(), 0);
    check_eq("evt_queue_drained", exp_evt.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
